// File: rtl/muldiv_sequencer_if.sv
// Issue/read bundle between the R-type decode path and the HI/LO multiply/divide sequencer.
// The master side is the pipeline and the slave side is the sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [5:0]      func_code;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            mfhi_en;
  logic            mflo_en;
  logic            busy;
  logic            stall;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] rd_data;

  modport master (
    output start, func_code, rs_data, rt_data, mfhi_en, mflo_en,
    input  busy, stall, done, div_by_zero, hi, lo, rd_data
  );

  modport slave (
    input  start, func_code, rs_data, rt_data, mfhi_en, mflo_en,
    output busy, stall, done, div_by_zero, hi, lo, rd_data
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: fixed 34-cycle shift-add multiply or restoring divide.
// It owns HI/LO, serves mfhi/mflo reads and stalls the pipeline on collisions.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]   ONE_W   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2W  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ZERO_W  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_W  = {XLEN{1'b1}};

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + ONE_W) : v;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [4:0]        step_r;
  logic              is_div_r;
  logic              is_signed_r;
  logic [XLEN-1:0]   rs_r;
  logic [XLEN-1:0]   rt_r;
  logic [XLEN-1:0]   mag_a_r;
  logic [XLEN-1:0]   mag_b_r;
  logic [XLEN-1:0]   acc_hi_r;
  logic [XLEN-1:0]   acc_lo_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic              neg_res_r;
  logic              neg_rem_r;
  logic              dz_r;
  logic              done_r;
  logic              dz_out_r;
  logic              busy_r;

  logic              accept_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  assign accept_s = (state_r == ST_IDLE) && bus.start && (bus.func_code[5:2] == 4'b0110);

  // Next-state logic for the IDLE -> PREP -> RUN -> FIX sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_PREP;
        else          state_s = ST_IDLE;
      end
      ST_PREP: state_s = ST_RUN;
      ST_RUN: begin
        if (step_r == 5'd31) state_s = ST_FIX;
        else                 state_s = ST_RUN;
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // One iteration of shift-add multiply / restoring divide, plus sign correction
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mag_a_r} : {(XLEN+1){1'b0}});
    div_shift_s = {acc_hi_r, acc_lo_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, mag_b_r};
    // Borrow out of the 33-bit subtract means the shifted remainder was below the divisor
    div_ge_s    = ~div_diff_s[XLEN];
    if (neg_res_r) begin
      prod_fix_s = ~{acc_hi_r, acc_lo_r} + ONE_2W;
      quo_fix_s  = ~acc_lo_r + ONE_W;
    end else begin
      prod_fix_s = {acc_hi_r, acc_lo_r};
      quo_fix_s  = acc_lo_r;
    end
    if (neg_rem_r) rem_fix_s = ~acc_hi_r + ONE_W;
    else           rem_fix_s = acc_hi_r;
  end

  // Operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r      <= 5'd0;
      is_div_r    <= 1'b0;
      is_signed_r <= 1'b0;
      rs_r        <= ZERO_W;
      rt_r        <= ZERO_W;
      mag_a_r     <= ZERO_W;
      mag_b_r     <= ZERO_W;
      acc_hi_r    <= ZERO_W;
      acc_lo_r    <= ZERO_W;
      hi_r        <= ZERO_W;
      lo_r        <= ZERO_W;
      neg_res_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      dz_r        <= 1'b0;
      done_r      <= 1'b0;
      dz_out_r    <= 1'b0;
    end else begin
      done_r   <= (state_r == ST_FIX);
      dz_out_r <= (state_r == ST_FIX) && dz_r;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rs_r        <= bus.rs_data;
            rt_r        <= bus.rt_data;
            is_div_r    <= bus.func_code[1];
            is_signed_r <= ~bus.func_code[0];
          end
        end
        ST_PREP: begin
          mag_a_r   <= abs_val(rs_r, is_signed_r);
          mag_b_r   <= abs_val(rt_r, is_signed_r);
          neg_res_r <= is_signed_r && (rs_r[XLEN-1] ^ rt_r[XLEN-1]);
          neg_rem_r <= is_signed_r && rs_r[XLEN-1];
          dz_r      <= is_div_r && (rt_r == ZERO_W);
          acc_hi_r  <= ZERO_W;
          acc_lo_r  <= is_div_r ? abs_val(rs_r, is_signed_r) : abs_val(rt_r, is_signed_r);
          step_r    <= 5'd0;
        end
        ST_RUN: begin
          step_r <= step_r + 5'd1;
          if (is_div_r) begin
            acc_hi_r <= div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
            acc_lo_r <= {acc_lo_r[XLEN-2:0], div_ge_s};
          end else begin
            {acc_hi_r, acc_lo_r} <= {mul_sum_s, acc_lo_r[XLEN-1:1]};
          end
        end
        ST_FIX: begin
          if (dz_r) begin
            hi_r <= rs_r;
            lo_r <= ONES_W;
          end else if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*XLEN-1:XLEN];
            lo_r <= prod_fix_s[XLEN-1:0];
          end
        end
        default: begin
          step_r <= 5'd0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.stall       = busy_r && (bus.mfhi_en || bus.mflo_en || bus.start);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_out_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.rd_data     = bus.mfhi_en ? hi_r : lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO, a monitor checks on done.
module tb_muldiv_sequencer;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] model_lo = 32'h0;

  muldiv_sequencer_if #(.XLEN(32)) bus();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the scoreboard whenever the DUT signals done
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending op at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", 64'(bus.hi), 64'(mon_e.hi));
        check("lo", 64'(bus.lo), 64'(mon_e.lo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dz));
        check("rd_data_done", 64'(bus.rd_data), 64'(bus.mfhi_en ? mon_e.hi : mon_e.lo));
      end
    end
  end

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input logic hold_read, input int collide_at);
    int cnt;
    int st;
    @(negedge clk);
    bus.func_code = f;
    bus.rs_data   = a;
    bus.rt_data   = b;
    bus.start     = 1'b1;
    if (hold_read) bus.mflo_en = 1'b1;
    #1;
    check("idle_stall", 64'(bus.stall), 64'd0);
    if (hold_read) check("idle_read_old_lo", 64'(bus.rd_data), 64'(model_lo));
    exp_q.push_back('{hi: eh, lo: el, dz: edz});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.func_code = 6'd0;
    cnt = 0;
    st = 0;
    while (bus.busy && cnt < 60) begin
      cnt++;
      if (bus.stall) st++;
      if (cnt == collide_at) begin
        bus.func_code = 6'b011000;
        bus.rs_data   = 32'd3;
        bus.rt_data   = 32'd3;
        bus.start     = 1'b1;
        #1;
        check("collide_stall", 64'(bus.stall), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    check("busy_cycles", 64'(cnt), 64'd34);
    if (hold_read) check("read_stall_cycles", 64'(st), 64'd34);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("dz_pulse", 64'(bus.div_by_zero), 64'(edz));
    if (hold_read) check("done_cycle_stall", 64'(bus.stall), 64'd0);
    model_lo = el;
    @(posedge clk);
    #1;
    bus.mflo_en = 1'b0;
    check("done_clear", 64'(bus.done), 64'd0);
    check("dz_clear", 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    bus.start = 1'b0;
    bus.func_code = 6'd0;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.mfhi_en = 1'b0;
    bus.mflo_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    // Invalid func_code must be ignored
    @(negedge clk);
    bus.func_code = 6'b011100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("invalid_func_busy", 64'(bus.busy), 64'd0);

    run_op(6'b011000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, -1);
    run_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, -1);
    run_op(6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, -1);
    run_op(6'b011011, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 1'b0, -1);
    run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, -1);
    run_op(6'b011010, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1'b0, -1);
    run_op(6'b011001, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0, 1'b1, -1);
    run_op(6'b011011, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 10);

    // Asynchronous reset in the middle of RUN discards the operation
    @(negedge clk);
    bus.func_code = 6'b011000;
    bus.rs_data = 32'd10;
    bus.rt_data = 32'd20;
    bus.start = 1'b1;
    bus.mflo_en = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_run_busy", 64'(bus.busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_stall", 64'(bus.stall), 64'd0);
    check("async_hi", 64'(bus.hi), 64'd0);
    check("async_lo", 64'(bus.lo), 64'd0);
    bus.mflo_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("no_done_after_reset", 64'(dn), 64'd0);
    model_lo = 32'd0;
    run_op(6'b011001, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1, -1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource of the Mini-MIPS core. It accepts mult/multu/div/divu operations issued by the R-type decode path and runs a 32-step iterative shift-add multiply or restoring divide. It owns the HI and LO registers and serves mfhi/mflo reads. It raises a stall to the pipeline whenever a read or a new operation would collide with an operation still in flight.

## Interface
- XLEN, 32, operand/HI/LO width; only 32 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  issue strobe for the operation in func_code.
- func_code  in  6  operation select: 011000 mult, 011001 multu, 011010 div, 011011 divu; any other value is ignored.
- rs_data  in  XLEN  operand A (multiplicand / dividend).
- rt_data  in  XLEN  operand B (multiplier / divisor).
- mfhi_en  in  1  read request for HI.
- mflo_en  in  1  read request for LO.
- busy  out  1  operation in flight.
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  high together with done when a div/divu had rt_data = 0.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- rd_data  out  XLEN  read result; equals hi when mfhi_en is set, otherwise lo (combinational from registers).

## Operation
- FSM states:
  - IDLE: waits for an accepted start.
  - PREP: latches operand magnitudes and the result sign.
  - RUN: 32 iterations, counted by a 5-bit step counter.
  - FIX: applies sign correction and writes HI/LO.
- Transitions: IDLE -> PREP -> RUN (32 cycles) -> FIX -> IDLE. No early exit, including zero operands and divide by zero.
- Start acceptance: start is accepted only in IDLE and only with a valid func_code. Operands and op type are captured on that edge.
- Signed ops (mult, div):
  - PREP takes two's-complement magnitudes of both operands.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB; quotient truncates toward zero.
  - Remainder sign = signA.
- Unsigned ops (multu, divu): operands are used as-is and FIX applies no correction.
- Multiply result: 64-bit product; HI = bits [63:32], LO = bits [31:0].
- Divide result: LO = quotient, HI = remainder.
  - Divide by zero: HI = rs_data, LO = 0xFFFFFFFF, div_by_zero pulses with done.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, with no exception.
- busy is high in PREP, RUN and FIX.
- stall = busy AND (mfhi_en OR mflo_en OR start).
- start while busy: no effect on the running operation; the pipeline stall covers it.
- HI/LO change only at the FIX -> IDLE edge or on reset.
- Simultaneous read and start in IDLE: rd_data returns the pre-operation HI/LO and the new operation is accepted. No stall.
- Reset at any time:
  - State -> IDLE; counter, hi and lo -> 0.
  - busy, stall, done and div_by_zero -> 0.
  - Any in-flight result is discarded.

## Timing
- Accepted start at edge E0: busy is high from after E0.
- PREP occupies cycle E0..E1; RUN occupies E1..E33; FIX occupies E33..E34.
- hi/lo update at E34, and busy drops after E34.
- done (and div_by_zero if applicable) is high for exactly the cycle E34..E35.
- Fixed latency is 34 cycles from accept to visible result.
- A read in the done cycle returns the new value with no stall.
- A new start is accepted at E34 at the earliest (in IDLE, concurrent with the done pulse).
- rd_data, stall and busy are pure combinational or register outputs. There is no added latency on reads in IDLE.

## Test plan
- mult rs=0xFFFFFFFE, rt=3 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; done high for exactly 1 cycle; busy high for exactly 34 cycles.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed vs. unsigned divide:
  - div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7 / 2 -> LO=3, HI=1.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- div 5 / 0 -> HI=5, LO=0xFFFFFFFF; div_by_zero high only in the done cycle.
- Stall and collision:
  - Hold mflo_en high from E0: stall is high on all 34 busy cycles, and rd_data=new LO in the done cycle.
  - A start with different operands at cycle 10 is ignored, and the final HI/LO match the first op.
- Drop rst_n mid-RUN (cycle 10) -> busy, stall, hi and lo go to 0 immediately without a clock edge. No done pulse follows; a new start after release completes normally.
